// File: rtl/keccak_byte_feeder_pkg.sv
// Shared types and defaults for the Keccak byte feeder.
package keccak_pkg;

    localparam int WORD_BYTES_DEF = 4;
    localparam int LEN_W_DEF      = 32;

    // FILL gathers bytes, EMIT offers the staged word, EMIT_PAD offers the
    // trailing all-zero word after a message that ended on a word boundary.
    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_PAD = 2'd2
    } state_t;

endpackage

// File: rtl/keccak_byte_feeder_if.sv
// Byte stream in, word stream out, for the Keccak byte feeder.
// master = the feeder itself, slave = its environment (source + core).
interface keccak_byte_feeder_if
    import keccak_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int LEN_W      = LEN_W_DEF
);
    localparam int BN_W = $clog2(WORD_BYTES);

    logic [7:0]              s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [8*WORD_BYTES-1:0] in;
    logic                    in_ready;
    logic                    is_last;
    logic [BN_W-1:0]         byte_num;
    logic                    buffer_full;
    logic                    msg_done;
    logic [LEN_W-1:0]        msg_len;

    modport master (
        input  s_data, s_valid, s_last, buffer_full,
        output s_ready, in, in_ready, is_last, byte_num, msg_done, msg_len
    );

    modport slave (
        output s_data, s_valid, s_last, buffer_full,
        input  s_ready, in, in_ready, is_last, byte_num, msg_done, msg_len
    );

endinterface

// File: rtl/keccak_byte_feeder.sv
// Packs a byte stream into WORD_BYTES-wide words for a Keccak core,
// marking the final word and appending a zero pad word when a message
// ends exactly on a word boundary.
module keccak_byte_feeder
    import keccak_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    keccak_byte_feeder_if.master bus
);
    localparam int BN_W = $clog2(WORD_BYTES);
    localparam int W    = 8 * WORD_BYTES;

    state_t          state, state_n;
    logic [BN_W-1:0] lane;
    logic [W-1:0]    stage;
    logic            stage_last;
    logic [BN_W-1:0] stage_bn;
    logic            pad_pend;
    logic [LEN_W-1:0] byte_cnt;

    logic [W-1:0]     word_reg;
    logic             ready_reg;
    logic             last_reg;
    logic [BN_W-1:0]  bn_reg;
    logic             done_reg;
    logic [LEN_W-1:0] len_reg;

    logic            xfer;
    logic            emit;
    logic            full_word;
    logic [BN_W:0]   lane_nxt;
    logic [W-1:0]    stage_ins;

    assign bus.s_ready  = (state == FILL) && !reset;
    assign bus.in       = word_reg;
    assign bus.in_ready = ready_reg;
    assign bus.is_last  = last_reg;
    assign bus.byte_num = bn_reg;
    assign bus.msg_done = done_reg;
    assign bus.msg_len  = len_reg;

    // Handshake decode, byte insertion into the current lane, next state.
    always_comb begin
        xfer      = bus.s_valid && (state == FILL);
        emit      = (state != FILL) && !bus.buffer_full;
        lane_nxt  = (BN_W+1)'(lane) + 1'b1;
        full_word = (lane_nxt == (BN_W+1)'(WORD_BYTES));
        stage_ins = stage;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (lane == BN_W'(k)) stage_ins[W-1-8*k -: 8] = bus.s_data;
        end
        state_n = state;
        case (state)
            FILL:     if (xfer && (full_word || bus.s_last)) state_n = EMIT;
            EMIT:     if (emit) state_n = pad_pend ? EMIT_PAD : FILL;
            EMIT_PAD: if (emit) state_n = FILL;
            default:  state_n = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_n;
    end

    // Staging, byte counter and registered word outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane       <= '0;
            stage      <= '0;
            stage_last <= 1'b0;
            stage_bn   <= '0;
            pad_pend   <= 1'b0;
            byte_cnt   <= '0;
            word_reg   <= '0;
            ready_reg  <= 1'b0;
            last_reg   <= 1'b0;
            bn_reg     <= '0;
            done_reg   <= 1'b0;
            len_reg    <= '0;
        end else begin
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            if (xfer) begin
                if (byte_cnt != '1) byte_cnt <= byte_cnt + LEN_W'(1);
                stage <= stage_ins;
                if (full_word) begin
                    // A last byte that fills the word leaves the end marker
                    // to a separate zero word.
                    lane       <= '0;
                    stage_last <= 1'b0;
                    stage_bn   <= '0;
                    pad_pend   <= bus.s_last;
                end else begin
                    lane       <= lane_nxt[BN_W-1:0];
                    stage_last <= bus.s_last;
                    stage_bn   <= lane_nxt[BN_W-1:0];
                end
            end
            if (emit) begin
                word_reg  <= stage;
                last_reg  <= stage_last;
                bn_reg    <= stage_bn;
                ready_reg <= 1'b1;
                done_reg  <= stage_last;
                if (stage_last) begin
                    len_reg  <= byte_cnt;
                    byte_cnt <= '0;
                end
                // Clear staging so unfilled lanes of the next word read zero;
                // a pending pad becomes the next staged word.
                lane       <= '0;
                stage      <= '0;
                stage_last <= pad_pend;
                stage_bn   <= '0;
                pad_pend   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keccak_byte_feeder.sv
// Directed bench for keccak_byte_feeder: a message-level model predicts the
// word sequence, one compare process checks every emitted word.
module tb_keccak_byte_feeder;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    keccak_byte_feeder_if #(.WORD_BYTES(4), .LEN_W(4))  ba ();
    keccak_byte_feeder_if #(.WORD_BYTES(8), .LEN_W(32)) bb ();

    keccak_byte_feeder #(.WORD_BYTES(4), .LEN_W(4))  dut_a (.clk(clk), .reset(reset), .bus(ba.master));
    keccak_byte_feeder #(.WORD_BYTES(8), .LEN_W(32)) dut_b (.clk(clk), .reset(reset), .bus(bb.master));

    typedef struct {
        logic [63:0] w;
        logic        last;
        int          bn;
        longint      len;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [63:0] seen_a[$];
    int          last_bn_a;
    longint      last_len_a;
    longint      last_len_b;
    int          cnt_b;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_pre;
    int          ir_cyc;
    logic        ir_seen;
    int          sent_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Message -> expected word list, straight from the packing rules.
    function automatic void model(input int d, input byte unsigned m[$]);
        int     wb = (d == 0) ? 4 : 8;
        longint maxlen = (d == 0) ? 64'd15 : 64'hFFFF_FFFF;
        int     n = m.size();
        exp_t   e;
        e.len = (n > maxlen) ? maxlen : n;
        for (int base = 0; base < n; base += wb) begin
            e.w = '0;
            for (int k = 0; k < wb && base + k < n; k++)
                e.w |= 64'(m[base+k]) << (8 * (wb - 1 - k));
            e.last = (base + wb > n);
            e.bn   = e.last ? n - base : 0;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (n % wb == 0) begin
            e.w = '0; e.last = 1'b1; e.bn = 0;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
        end
    endfunction

    task automatic check_out(input int d, input logic ir, input logic [63:0] w, input logic il,
                             input int bn, input logic md, input logic [63:0] ml);
        exp_t e;
        if (ir) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
                chk($sformatf("unexpected_word_%0d", d), 64'(ir), 64'd0);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("word_%0d", d), w, e.w);
                chk($sformatf("is_last_%0d", d), 64'(il), 64'(e.last));
                chk($sformatf("byte_num_%0d", d), 64'(bn), 64'(e.bn));
                chk($sformatf("msg_done_%0d", d), 64'(md), 64'(e.last));
                if (e.last) chk($sformatf("msg_len_%0d", d), ml, 64'(e.len));
                if (d == 0) begin
                    seen_a.push_back(w);
                    last_bn_a = bn;
                    if (md) last_len_a = longint'(ml);
                    if (!ir_seen) begin ir_cyc = cyc; ir_seen = 1'b1; end
                end else begin
                    cnt_b++;
                    if (md) last_len_b = longint'(ml);
                end
            end
        end else begin
            chk($sformatf("stray_msg_done_%0d", d), 64'(md), 64'd0);
        end
    endtask

    // Compare process: every cycle out of reset, both feeders.
    always @(negedge clk) begin
        if (!reset) begin
            check_out(0, ba.in_ready, 64'(ba.in), ba.is_last, int'(ba.byte_num), ba.msg_done, 64'(ba.msg_len));
            check_out(1, bb.in_ready, 64'(bb.in), bb.is_last, int'(bb.byte_num), bb.msg_done, 64'(bb.msg_len));
        end
    end

    task automatic send_byte(input int d, input byte unsigned b, input logic last);
        int t = 0;
        @(negedge clk);
        if (d == 0) begin ba.s_valid = 1'b1; ba.s_data = b; ba.s_last = last; end
        else        begin bb.s_valid = 1'b1; bb.s_data = b; bb.s_last = last; end
        while (!((d == 0) ? ba.s_ready : bb.s_ready)) begin
            t++;
            if (t > 500) begin chk("send_timeout", 64'(t), 64'd0); return; end
            @(negedge clk);
        end
        acc_pre = cyc;
        @(posedge clk);
        if (d == 0) sent_a++;
    endtask

    task automatic idle_src();
        @(negedge clk);
        ba.s_valid = 1'b0; ba.s_last = 1'b0;
        bb.s_valid = 1'b0; bb.s_last = 1'b0;
    endtask

    task automatic send_msg(input int d, input byte unsigned m[$]);
        model(d, m);
        for (int i = 0; i < m.size(); i++) send_byte(d, m[i], i == m.size() - 1);
        idle_src();
    endtask

    task automatic drain(input int d);
        int t = 0;
        while (((d == 0) ? qa.size() : qb.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain_%0d", d), 64'((d == 0) ? qa.size() : qb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_a();
        seen_a.delete();
        ir_seen = 1'b0;
        sent_a = 0;
    endtask

    byte unsigned m[$];
    logic         stop_b;

    initial begin
        ba.s_valid = 0; ba.s_data = 0; ba.s_last = 0; ba.buffer_full = 0;
        bb.s_valid = 0; bb.s_data = 0; bb.s_last = 0; bb.buffer_full = 0;
        cnt_b = 0; stop_b = 0;
        clear_a();
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(ba.s_ready), 64'd0);
        chk("rst_in", 64'(ba.in), 64'd0);
        chk("rst_in_ready", 64'(ba.in_ready), 64'd0);
        chk("rst_is_last", 64'(ba.is_last), 64'd0);
        chk("rst_byte_num", 64'(ba.byte_num), 64'd0);
        chk("rst_msg_done", 64'(ba.msg_done), 64'd0);
        chk("rst_msg_len", 64'(ba.msg_len), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(ba.s_ready), 64'd1);

        // "abc": one partial final word, two-edge latency.
        clear_a();
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(0, m);
        drain(0);
        chk("abc_count", 64'(seen_a.size()), 64'd1);
        chk("abc_word", seen_a[0], 64'h6162_6300);
        chk("abc_bn", 64'(last_bn_a), 64'd3);
        chk("abc_len", 64'(last_len_a), 64'd3);
        chk("abc_latency", 64'(ir_cyc - acc_pre), 64'd2);

        // "abcd": full word then zero pad word.
        clear_a();
        m = '{8'h61, 8'h62, 8'h63, 8'h64};
        send_msg(0, m);
        drain(0);
        chk("abcd_count", 64'(seen_a.size()), 64'd2);
        chk("abcd_word0", seen_a[0], 64'h6162_6364);
        chk("abcd_word1", seen_a[1], 64'h0);
        chk("abcd_bn", 64'(last_bn_a), 64'd0);
        chk("abcd_len", 64'(last_len_a), 64'd4);

        // "hello" with the core stalled for 10 cycles at the first word.
        clear_a();
        ba.buffer_full = 1'b1;
        m = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
        fork
            send_msg(0, m);
            begin
                int t = 0;
                while (sent_a < 4 && t < 200) begin @(negedge clk); t++; end
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_in_ready", 64'(ba.in_ready), 64'd0);
                    chk("hold_s_ready", 64'(ba.s_ready), 64'd0);
                end
                ba.buffer_full = 1'b0;
            end
        join
        drain(0);
        chk("hello_count", 64'(seen_a.size()), 64'd2);
        chk("hello_word0", seen_a[0], 64'h6865_6c6c);
        chk("hello_word1", seen_a[1], 64'h6f00_0000);
        chk("hello_bn", 64'(last_bn_a), 64'd1);
        chk("hello_len", 64'(last_len_a), 64'd5);

        // Reset after two bytes discards them.
        clear_a();
        send_byte(0, 8'h77, 1'b0);
        send_byte(0, 8'h78, 1'b0);
        idle_src();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_word_after_reset", 64'(ba.in_ready), 64'd0);
        end
        m = '{8'h31};
        send_msg(0, m);
        drain(0);
        chk("rst_msg_count", 64'(seen_a.size()), 64'd1);
        chk("rst_msg_word", seen_a[0], 64'h3100_0000);
        chk("rst_msg_bn", 64'(last_bn_a), 64'd1);
        chk("rst_msg_len", 64'(last_len_a), 64'd1);

        // 20 bytes on a 4-bit length counter saturates at 15.
        clear_a();
        m.delete();
        for (int i = 0; i < 20; i++) m.push_back(8'(i + 1));
        send_msg(0, m);
        drain(0);
        chk("sat_count", 64'(seen_a.size()), 64'd6);
        chk("sat_word4", seen_a[4], 64'h1112_1314);
        chk("sat_pad", seen_a[5], 64'h0);
        chk("sat_len", 64'(last_len_a), 64'd15);

        // 8-byte words, 2000 random bytes, random core back-pressure.
        m.delete();
        for (int i = 0; i < 2000; i++) m.push_back(8'($urandom));
        fork
            begin
                send_msg(1, m);
                drain(1);
                stop_b = 1'b1;
            end
            begin
                while (!stop_b) begin
                    @(negedge clk);
                    bb.buffer_full = ($urandom_range(0, 3) == 0);
                end
                bb.buffer_full = 1'b0;
            end
        join
        chk("big_count", 64'(cnt_b), 64'd251);
        chk("big_len", 64'(last_len_b), 64'd2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
